// File: rtl/pipe_pkg.sv
// Purpose: shared types for the pipe_stage_skid pipeline register.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package pipe_pkg;

    // Occupancy of the stage: head only, or head plus skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Bubble payload bit; a NOP beat is all-zero at any width.
    localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Purpose: upstream/downstream valid-ready handshake bundle for one pipeline stage.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the stall in each direction.
// Ports: in_valid/in_ready/in_data (upstream beat), out_valid/out_ready/out_data (head beat).
//   slave  = the stage itself, master = the surrounding pipeline driving it.
interface pipe_stage_skid_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_entry.sv
// Purpose: one payload register with valid bit; output reads as NOP when invalid.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owning FSM decides when to load or drop.
// Ports: CLK, rst (async active-low), clr (flush), load (capture d), drop (release),
//   d (payload in), vld (entry holds a beat), q (payload, zero when !vld).
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] d,
    output logic             vld,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] dat;

    // Flush beats load: a beat handed over in the flush cycle is discarded.
    // Load beats drop: head replaced in the same cycle it is consumed.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
            dat <= {WIDTH{NOP_BIT}};
        end else if (clr) begin
            vld <= 1'b0;
            dat <= {WIDTH{NOP_BIT}};
        end else if (load) begin
            vld <= 1'b1;
            dat <= d;
        end else if (drop) begin
            vld <= 1'b0;
            dat <= {WIDTH{NOP_BIT}};
        end
    end

    assign q = vld ? dat : {WIDTH{NOP_BIT}};

endmodule

// File: rtl/pipe_stage_skid.sv
// Purpose: generic inter-stage pipeline register with optional 2-entry skid buffer, flush, stall counter.
// Latency: 1 cycle in->out when empty; 1 beat/cycle sustained in both SKID modes.
// Backpressure: SKID=1 in_ready is registered (state != TWO); SKID=0 in_ready = !out_valid || out_ready.
// Ports: CLK, rst (async active-low), CLR (sync flush), bus (slave handshake bundle),
//   stall_cnt (saturating count of cycles with out_valid && !out_ready; survives CLR).
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             CLR,
    pipe_stage_skid_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           state_q;
    state_t           state_nxt;
    logic             in_rdy;
    logic             in_xfer;
    logic             out_xfer;
    logic             head_vld;
    logic             head_load;
    logic             head_drop;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] head_q;
    logic             skid_vld;
    logic             skid_load;
    logic             skid_drop;
    logic [WIDTH-1:0] skid_q;
    logic [CNT_W-1:0] cnt_q;

    assign in_xfer  = bus.in_valid && in_rdy;
    assign out_xfer = head_vld && bus.out_ready;

    // Head refills from the skid entry whenever it holds the older beat.
    assign head_d = skid_vld ? skid_q : bus.in_data;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        head_load = 1'b0;
        head_drop = 1'b0;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        if (CLR) begin
            // Entries clear themselves via clr; a concurrent out_xfer is
            // simply consumed and any concurrent in beat is lost.
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_nxt = ST_ONE;
                        head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_load = 1'b1;
                    end else if (in_xfer) begin
                        // Only reachable with SKID=1: SKID=0 accepts in ONE
                        // solely when out_ready is high.
                        state_nxt = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = ST_EMPTY;
                        head_drop = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_nxt = ST_ONE;
                        head_load = 1'b1;
                        skid_drop = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_entry #(.WIDTH(WIDTH)) u_head (
        .CLK  (CLK),
        .rst  (rst),
        .clr  (CLR),
        .load (head_load),
        .drop (head_drop),
        .d    (head_d),
        .vld  (head_vld),
        .q    (head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            pipe_entry #(.WIDTH(WIDTH)) u_skid (
                .CLK  (CLK),
                .rst  (rst),
                .clr  (CLR),
                .load (skid_load),
                .drop (skid_drop),
                .d    (bus.in_data),
                .vld  (skid_vld),
                .q    (skid_q)
            );

            // Ready comes from a flop fed by the next state, so out_ready
            // never reaches in_ready combinationally.
            always_ff @(posedge CLK or negedge rst) begin
                if (!rst) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_nxt != ST_TWO);
                end
            end

            assign in_rdy = rdy_q;
        end else begin : g_noskid
            assign skid_vld = 1'b0;
            assign skid_q   = {WIDTH{NOP_BIT}};
            assign in_rdy   = !head_vld || bus.out_ready;
        end
    endgenerate

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (head_vld && !bus.out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = head_vld;
    assign bus.out_data  = head_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    logic CLR = 1'b0;

    always #5 CLK = ~CLK;

    pipe_stage_skid_if #(.WIDTH(32)) ia ();
    pipe_stage_skid_if #(.WIDTH(32)) ib ();
    pipe_stage_skid_if #(.WIDTH(32)) ic ();

    logic [15:0] stall_a;
    logic [3:0]  stall_b;
    logic [15:0] stall_c;

    pipe_stage_skid #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut_a (
        .CLK(CLK), .rst(rst), .CLR(CLR), .bus(ia), .stall_cnt(stall_a));
    pipe_stage_skid #(.WIDTH(32), .SKID(1), .CNT_W(4)) dut_b (
        .CLK(CLK), .rst(rst), .CLR(CLR), .bus(ib), .stall_cnt(stall_b));
    pipe_stage_skid #(.WIDTH(32), .SKID(0), .CNT_W(16)) dut_c (
        .CLK(CLK), .rst(rst), .CLR(CLR), .bus(ic), .stall_cnt(stall_c));

    int checks = 0;
    int errors = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];
    int exp_sa = 0;
    int exp_sb = 0;
    int exp_sc = 0;

    // One cycle on instance A (SKID=1, 16-bit counter); the queue is the model occupancy.
    task automatic step_a(input logic v, input logic [31:0] d, input logic ordy,
                          input logic clr, output logic acc, output logic outx);
        logic [31:0] e;
        logic        stl;
        @(negedge CLK);
        ia.in_valid = v; ia.in_data = d; ia.out_ready = ordy; CLR = clr;
        #1;
        checks++;
        if (ia.out_valid !== (qa.size() > 0)) begin
            errors++; $display("FAIL a_out_valid got %b want %b", ia.out_valid, qa.size() > 0);
        end
        checks++;
        if (ia.in_ready !== (qa.size() < 2)) begin
            errors++; $display("FAIL a_in_ready got %b want %b", ia.in_ready, qa.size() < 2);
        end
        checks++;
        if (stall_a !== exp_sa[15:0]) begin
            errors++; $display("FAIL a_stall_cnt got %0d want %0d", stall_a, exp_sa);
        end
        if (qa.size() == 0) begin
            checks++;
            if (ia.out_data !== 32'h0) begin
                errors++; $display("FAIL a_bubble_data got %h want 0", ia.out_data);
            end
        end
        acc  = v && (qa.size() < 2);
        outx = (qa.size() > 0) && ordy;
        stl  = (qa.size() > 0) && !ordy;
        if (outx) begin
            e = qa.pop_front();
            checks++;
            if (ia.out_data !== e) begin
                errors++; $display("FAIL a_out_data got %h want %h", ia.out_data, e);
            end
        end
        if (stl && exp_sa < 65535) exp_sa++;
        if (clr) qa.delete();
        else if (acc) qa.push_back(d);
    endtask

    // Instance B: SKID=1 with a 4-bit saturating counter.
    task automatic step_b(input logic v, input logic [31:0] d, input logic ordy,
                          output logic acc);
        logic [31:0] e;
        logic        stl;
        @(negedge CLK);
        ib.in_valid = v; ib.in_data = d; ib.out_ready = ordy; CLR = 1'b0;
        #1;
        checks++;
        if (stall_b !== exp_sb[3:0]) begin
            errors++; $display("FAIL b_stall_cnt got %0d want %0d", stall_b, exp_sb);
        end
        checks++;
        if (ib.out_valid !== (qb.size() > 0)) begin
            errors++; $display("FAIL b_out_valid got %b want %b", ib.out_valid, qb.size() > 0);
        end
        acc = v && (qb.size() < 2);
        stl = (qb.size() > 0) && !ordy;
        if ((qb.size() > 0) && ordy) begin
            e = qb.pop_front();
            checks++;
            if (ib.out_data !== e) begin
                errors++; $display("FAIL b_out_data got %h want %h", ib.out_data, e);
            end
        end
        if (stl && exp_sb < 15) exp_sb++;
        if (acc) qb.push_back(d);
    endtask

    // Instance C: SKID=0, in_ready is combinational from out_ready.
    task automatic step_c(input logic v, input logic [31:0] d, input logic ordy,
                          output logic acc, output logic outx);
        logic [31:0] e;
        logic        rdy;
        logic        stl;
        @(negedge CLK);
        ic.in_valid = v; ic.in_data = d; ic.out_ready = ordy; CLR = 1'b0;
        #1;
        rdy = (qc.size() == 0) || ordy;
        checks++;
        if (ic.in_ready !== rdy) begin
            errors++; $display("FAIL c_in_ready got %b want %b", ic.in_ready, rdy);
        end
        checks++;
        if (ic.out_valid !== (qc.size() > 0)) begin
            errors++; $display("FAIL c_out_valid got %b want %b", ic.out_valid, qc.size() > 0);
        end
        checks++;
        if (stall_c !== exp_sc[15:0]) begin
            errors++; $display("FAIL c_stall_cnt got %0d want %0d", stall_c, exp_sc);
        end
        acc  = v && rdy;
        outx = (qc.size() > 0) && ordy;
        stl  = (qc.size() > 0) && !ordy;
        if (outx) begin
            e = qc.pop_front();
            checks++;
            if (ic.out_data !== e) begin
                errors++; $display("FAIL c_out_data got %h want %h", ic.out_data, e);
            end
        end
        if (stl && exp_sc < 65535) exp_sc++;
        if (acc) qc.push_back(d);
    endtask

    task automatic test_reset();
        ia.in_valid = 1'b1; ia.in_data = 32'hDEAD; ia.out_ready = 1'b0;
        ib.in_valid = 1'b1; ib.in_data = 32'hDEAD; ib.out_ready = 1'b0;
        ic.in_valid = 1'b1; ic.in_data = 32'hDEAD; ic.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", ia.out_valid); end
        checks++;
        if (ia.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", ia.out_data); end
        checks++;
        if (stall_a !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_a); end
        checks++;
        if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", ia.in_ready); end
        checks++;
        if (ic.in_ready !== 1'b1) begin errors++; $display("FAIL rst_c_in_ready got %b want 1", ic.in_ready); end
        checks++;
        if (ib.out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_out_valid got %b want 0", ib.out_valid); end
        @(negedge CLK);
        ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
        ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic acc, outx;
        int   nout = 0;
        for (int i = 0; i < 10; i++) begin
            step_a(i < 8, 32'(i + 1), 1'b1, 1'b0, acc, outx);
            if (i >= 1 && i <= 8 && outx) nout++;
        end
        checks++;
        if (nout != 8) begin errors++; $display("FAIL stream_no_bubble got %0d beats want 8", nout); end
    endtask

    task automatic test_backpressure();
        logic acc, outx;
        int   nout = 0;
        logic done = 1'b0;
        step_a(1'b1, 32'hA, 1'b1, 1'b0, acc, outx);
        step_a(1'b1, 32'hB, 1'b0, 1'b0, acc, outx);
        repeat (4) step_a(1'b1, 32'hC, 1'b0, 1'b0, acc, outx);
        for (int i = 0; i < 8 && !done; i++) begin
            step_a(1'b1, 32'hC, 1'b1, 1'b0, acc, outx);
            if (outx) nout++;
            done = acc;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL bp_accept_c got not accepted want accepted"); end
        repeat (4) begin
            step_a(1'b0, 32'h0, 1'b1, 1'b0, acc, outx);
            if (outx) nout++;
        end
        checks++;
        if (nout != 3) begin errors++; $display("FAIL bp_delivered got %0d want 3", nout); end
    endtask

    task automatic test_flush();
        logic acc, outx;
        step_a(1'b1, 32'h11, 1'b0, 1'b0, acc, outx);
        step_a(1'b1, 32'h22, 1'b0, 1'b0, acc, outx);
        step_a(1'b1, 32'h33, 1'b0, 1'b1, acc, outx);
        repeat (3) step_a(1'b0, 32'h0, 1'b1, 1'b0, acc, outx);
        // Flush from ONE while a beat is both consumed and offered.
        step_a(1'b1, 32'h44, 1'b1, 1'b0, acc, outx);
        step_a(1'b1, 32'h55, 1'b1, 1'b1, acc, outx);
        repeat (3) step_a(1'b0, 32'h0, 1'b1, 1'b0, acc, outx);
    endtask

    task automatic test_saturation();
        logic acc;
        step_b(1'b1, 32'h77, 1'b0, acc);
        repeat (20) step_b(1'b0, 32'h0, 1'b0, acc);
        checks++;
        if (stall_b !== 4'd15) begin errors++; $display("FAIL sat_stall_cnt got %0d want 15", stall_b); end
        repeat (3) step_b(1'b0, 32'h0, 1'b1, acc);
        checks++;
        if (stall_b !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_b); end
    endtask

    task automatic test_noskid();
        logic acc, outx;
        int   nout = 0;
        for (int i = 0; i < 8; i++) begin
            step_c(1'b1, 32'h100 + 32'(i), 1'b1, acc, outx);
            if (i >= 1 && outx) nout++;
        end
        checks++;
        if (nout != 7) begin errors++; $display("FAIL noskid_throughput got %0d want 7", nout); end
        step_c(1'b1, 32'h200, 1'b0, acc, outx);
        step_c(1'b1, 32'h200, 1'b1, acc, outx);
        step_c(1'b1, 32'h201, 1'b1, acc, outx);
        repeat (2) step_c(1'b0, 32'h0, 1'b1, acc, outx);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_noskid();
        checks++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            errors++; $display("FAIL drain_empty got %0d beats left want 0", qa.size() + qb.size() + qc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
